// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default sizes for the PWM core.
// Holds the dead-time FSM state encoding used by pwm_core.
package pwm_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int DEADTIME_DEF = 2;
  localparam int DT_W_DEF     = 4;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_DEAD = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/deadtime_inserter.sv
// deadtime_inserter: complementary output FSM with dead time.
// Ports: clk, rst (async, high), en, pwm_raw in;
//        pwm_h, pwm_l, dt_active out (decoded from state).
module deadtime_inserter
  import pwm_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEF,
  parameter int DT_W     = DT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pwm_raw,
  output logic pwm_h,
  output logic pwm_l,
  output logic dt_active
);

  localparam bit NO_DT = (DEADTIME == 0);
  localparam logic [DT_W-1:0] DT_LAST =
    NO_DT ? '0 : DT_W'(DEADTIME - 1);

  state_t          state;
  state_t          state_n;
  state_t          tgt;
  logic [DT_W-1:0] dtc;
  logic [DT_W-1:0] dtc_n;
  logic            flip;

  assign tgt = pwm_raw ? S_HIGH : S_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
      dtc   <= '0;
    end else begin
      state <= state_n;
      dtc   <= dtc_n;
    end
  end

  // flip: the driven side no longer matches raw
  always_comb begin
    flip = 1'b0;
    unique case (state)
      S_OFF:   flip = 1'b1;
      S_HIGH:  flip = !pwm_raw;
      S_LOW:   flip = pwm_raw;
      default: flip = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    dtc_n   = dtc;
    if (!en) begin
      state_n = S_OFF;
      dtc_n   = '0;
    end else if (state == S_DEAD) begin
      // target side is sampled only at expiry
      dtc_n = dtc + 1'b1;
      if (dtc == DT_LAST)
        state_n = tgt;
    end else if (flip) begin
      if (NO_DT) begin
        state_n = tgt;
      end else begin
        state_n = S_DEAD;
        dtc_n   = '0;
      end
    end
  end

  assign pwm_h     = (state == S_HIGH);
  assign pwm_l     = (state == S_LOW);
  assign dt_active = (state == S_DEAD);

  a_no_shoot: assert property (
    @(posedge clk) disable iff (rst)
    !(pwm_h && pwm_l)
  );

endmodule

// File: rtl/pwm_core.sv
// pwm_core: period counter, rollover strobe, raw PWM, dead time.
// Ports: clk, rst, en, duty_reg, period_reg in; rollover, cnt,
//        pwm_raw, pwm_h, pwm_l, dt_active out.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEADTIME = DEADTIME_DEF,
  parameter int DT_W     = DT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] duty_reg,
  input  logic [WIDTH-1:0] period_reg,
  output logic             rollover,
  output logic [WIDTH-1:0] cnt,
  output logic             pwm_raw,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             dt_active
);

  logic             p_zero;
  logic             at_end;
  logic [WIDTH-1:0] p_last;

  assign p_zero = (period_reg == '0);
  assign p_last = p_zero ? '0 : period_reg - 1'b1;
  assign at_end = !p_zero && (cnt == p_last);

  // Idle/zero-period must strobe so the register
  // stage can leave its 0/0 reset values.
  assign rollover = !en || p_zero || at_end;
  assign pwm_raw  = en && !p_zero && (cnt < duty_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (rollover)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  deadtime_inserter #(
    .DEADTIME (DEADTIME),
    .DT_W     (DT_W)
  ) u_dt (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_raw   (pwm_raw),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .dt_active (dt_active)
  );

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: table, directed and random checks of pwm_core.
// Two DUTs share stimulus: DEADTIME=2 and DEADTIME=0.
module tb_pwm_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] duty_reg;
  logic [7:0] period_reg;

  logic       roll2, raw2, h2, l2, dt2;
  logic [7:0] cnt2;
  logic       roll0, raw0, h0, l0, dt0;
  logic [7:0] cnt0;

  always #5 clk = ~clk;

  pwm_core #(.WIDTH(8), .DEADTIME(2), .DT_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en),
    .duty_reg(duty_reg), .period_reg(period_reg),
    .rollover(roll2), .cnt(cnt2), .pwm_raw(raw2),
    .pwm_h(h2), .pwm_l(l2), .dt_active(dt2)
  );

  pwm_core #(.WIDTH(8), .DEADTIME(0), .DT_W(4)) dut0 (
    .clk(clk), .rst(rst), .en(en),
    .duty_reg(duty_reg), .period_reg(period_reg),
    .rollover(roll0), .cnt(cnt0), .pwm_raw(raw0),
    .pwm_h(h0), .pwm_l(l0), .dt_active(dt0)
  );

  int passed = 0;
  int total  = 0;

  // reference: counter position, active/shadow regs
  int mc, mp, md, sp, sd;
  // per DUT: driven side (-1 none) and dead cycles left
  int side [2];
  int dl   [2];

  typedef struct {
    int d; int p;
    int h2; int l2; int dt2;
    int h0; int l0;
  } vec_t;
  vec_t vt [7];

  function automatic int dtv(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit mraw();
    return en && (mp != 0) && (mc < md);
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mc = 0; mp = 0; md = 0;
    side[0] = -1; side[1] = -1;
    dl[0] = 0; dl[1] = 0;
    period_reg = 8'd0;
    duty_reg   = 8'd0;
  endtask

  task automatic compare();
    bit r;
    r = mraw();
    chk("cnt2", int'(cnt2), mc);
    chk("cnt0", int'(cnt0), mc);
    chk("roll2", int'(roll2),
        int'(!en || mp == 0 || mc == mp - 1));
    chk("roll0", int'(roll0), int'(roll2 === 1'b1));
    chk("raw2", int'(raw2), int'(r));
    chk("raw0", int'(raw0), int'(r));
    chk("h2", int'(h2), int'(side[0] == 1));
    chk("l2", int'(l2), int'(side[0] == 0));
    chk("dt2", int'(dt2), int'(dl[0] > 0));
    chk("h0", int'(h0), int'(side[1] == 1));
    chk("l0", int'(l0), int'(side[1] == 0));
    chk("dt0", int'(dt0), 0);
  endtask

  task automatic cyc();
    bit r, roll;
    r    = mraw();
    roll = !en || mp == 0 || mc == mp - 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!en) begin
        side[i] = -1; dl[i] = 0;
      end else if (dl[i] > 0) begin
        dl[i]--;
        if (dl[i] == 0) side[i] = int'(r);
      end else if (side[i] != int'(r)) begin
        if (dtv(i) == 0) side[i] = int'(r);
        else begin side[i] = -1; dl[i] = dtv(i); end
      end
    end
    mc = roll ? 0 : mc + 1;
    if (roll) begin mp = sp; md = sd; end
    period_reg = 8'(mp);
    duty_reg   = 8'(md);
    #1;
    compare();
  endtask

  task automatic wait_cnt(int v);
    int n = 0;
    while (mc != v && n < 50) begin cyc(); n++; end
    chk("wait_cnt", mc, v);
  endtask

  task automatic pulse_rst(string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_cnt"}, int'(cnt2), 0);
    chk({tag, "_h"}, int'(h2), 0);
    chk({tag, "_l"}, int'(l2), 0);
    chk({tag, "_dt"}, int'(dt2), 0);
    chk({tag, "_h0"}, int'(h0), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nroll, ch2, cl2, cd2, ch0, cl0;
    vt[0] = '{5, 10, 6, 6, 8, 10, 10};
    vt[1] = '{1, 10, 0, 16, 4, 2, 18};
    vt[2] = '{6, 6, 20, 0, 0, 20, 0};
    vt[3] = '{0, 6, 0, 20, 0, 0, 20};
    vt[4] = '{1, 4, 0, 10, 10, 5, 15};
    vt[5] = '{3, 4, 10, 0, 10, 15, 5};
    vt[6] = '{8, 10, 16, 0, 4, 16, 4};

    rst = 1'b1; en = 1'b0; sp = 0; sd = 0;
    model_reset();
    #2;
    chk("rst_cnt", int'(cnt2), 0);
    chk("rst_h", int'(h2), 0);
    chk("rst_l", int'(l2), 0);
    chk("rst_dt", int'(dt2), 0);
    chk("rst_l0", int'(l0), 0);
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("p0_roll", int'(roll2), 1);
      chk("p0_cnt", int'(cnt2), 0);
      chk("p0_h", int'(h2), 0);
    end
    sp = 4; sd = 1;
    cyc(); cyc();
    nroll = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      nroll += int'(roll2);
    end
    chk("p4_rolls", nroll, 2);

    foreach (vt[j]) begin
      sp = vt[j].p; sd = vt[j].d;
      for (int k = 0; k < 24; k++) cyc();
      ch2 = 0; cl2 = 0; cd2 = 0; ch0 = 0; cl0 = 0;
      for (int k = 0; k < 20; k++) begin
        cyc();
        ch2 += int'(h2); cl2 += int'(l2);
        cd2 += int'(dt2);
        ch0 += int'(h0); cl0 += int'(l0);
      end
      chk($sformatf("v%0d_h2", j), ch2, vt[j].h2);
      chk($sformatf("v%0d_l2", j), cl2, vt[j].l2);
      chk($sformatf("v%0d_dt2", j), cd2, vt[j].dt2);
      chk($sformatf("v%0d_h0", j), ch0, vt[j].h0);
      chk($sformatf("v%0d_l0", j), cl0, vt[j].l0);
    end

    sp = 10; sd = 5;
    for (int k = 0; k < 20; k++) cyc();
    wait_cnt(3);
    en = 1'b0;
    cyc();
    chk("dis_cnt", int'(cnt2), 0);
    chk("dis_h", int'(h2), 0);
    chk("dis_l", int'(l2), 0);
    chk("dis_roll", int'(roll2), 1);
    cyc(); cyc();
    en = 1'b1;
    cyc(); chk("ren_dt1", int'(dt2), 1);
    cyc(); chk("ren_dt2", int'(dt2), 1);
    cyc(); chk("ren_h", int'(h2), 1);

    for (int k = 0; k < 20; k++) cyc();
    wait_cnt(3);
    pulse_rst("arst");
    for (int k = 0; k < 30; k++) cyc();

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        sp = $urandom_range(0, 12);
        sd = $urandom_range(0, sp + 1);
      end
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 299) == 0)
        pulse_rst("rrst");
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_core.md
Name: pwm_core

Overview:
- Downstream consumer of the PWM shadow/active register stage.
- Runs the period counter from the active duty_reg/period_reg values.
- Produces the rollover strobe that the register stage uses to commit new values at period boundaries.
- Generates a complementary high/low-side output pair with programmable dead-time insertion.

Parameters:
- WIDTH, 8, width of the duty/period values and the counter.
- DEADTIME, 2, number of cycles both outputs are held low at each transition; 0 disables dead time.
- DT_W, 4, width of the dead-time counter; must satisfy DEADTIME < 2^DT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  synchronous run enable.
- duty_reg  in  WIDTH  active duty value from the register stage.
- period_reg  in  WIDTH  active period value from the register stage.
- rollover  out  1  commit strobe back to the register stage.
- cnt  out  WIDTH  current counter value.
- pwm_raw  out  1  un-deadtimed PWM.
- pwm_h  out  1  high-side drive.
- pwm_l  out  1  low-side drive.
- dt_active  out  1  high while in the dead-time state.

Behaviour:
- Reset: cnt=0, FSM=OFF, pwm_h=0, pwm_l=0, dt_active=0, dead-time counter=0.
- Counter, with P=period_reg and D=duty_reg:
  - If en=1 and P!=0: cnt counts 0..P-1, then wraps to 0; the period is P cycles.
  - If en=0 or P=0: cnt is forced to 0 on the next edge.
- rollover (combinational from registered state):
  - = !en | (P==0) | (cnt==P-1).
  - Asserting it while disabled or while P=0 is mandatory. The register stage resets to 0/0 and only loads on rollover, so without this the design deadlocks.
  - New D/P values commit on the same edge where cnt wraps to 0, so they take effect at cnt=0.
- pwm_raw (combinational) = en & (P!=0) & (cnt < D).
  - D=0 gives 0%.
  - D>=P gives 100%; D==P is legal upstream.
- Width rule: P-1 is computed only when P!=0; no wrap-around compare.
- FSM states: OFF, DEAD, HIGH, LOW (registered; outputs are decoded from the state register).
  - Any state with en=0 goes to OFF next edge; this has priority over all other transitions.
  - OFF with en=1: go to DEAD and load dtc=0.
  - HIGH with pwm_raw=0: go to DEAD and load dtc=0.
  - LOW with pwm_raw=1: go to DEAD and load dtc=0.
  - DEAD: dtc increments each cycle. When dtc==DEADTIME-1, go to HIGH if pwm_raw=1, else LOW.
  - pwm_raw toggling during DEAD does not restart the count; the target is sampled at expiry.
  - DEADTIME=0: DEAD is never entered. OFF/HIGH/LOW go directly to the state matching pwm_raw; OFF with en=1 goes to HIGH or LOW the same way.
- Outputs:
  - pwm_h = (state==HIGH), pwm_l = (state==LOW), dt_active = (state==DEAD).
  - pwm_h & pwm_l is never 1 (assertion).
- Latency: the edge of pwm_raw reaches the FSM output after 1 cycle, plus DEADTIME cycles of both-low.
- A high pulse of D cycles yields D-DEADTIME cycles of pwm_h; the same rule applies to the low side.
- Pulses of length <= DEADTIME are swallowed: the output returns to the prior side, or switches if raw has settled at the new level at expiry.
- Period shrinking below cnt cannot occur, because values only change at the wrap.
- Mid-operation async reset returns everything to reset values immediately.
- When en rises: cnt starts at 0, the FSM passes through DEAD (both low) before driving either side.

Decomposition:
- Package pwm_pkg holds:
  - FSM state typedef/encoding (OFF=2'd0, DEAD=2'd1, HIGH=2'd2, LOW=2'd3).
  - Default WIDTH/DEADTIME/DT_W constants.
- Sub-module deadtime_inserter holds the FSM and dead-time counter; it takes pwm_raw/en and outputs pwm_h/pwm_l/dt_active.
- pwm_core keeps the counter, rollover and pwm_raw logic.

Test Plan:
- Reset release, en=1, P=0/D=0 (register stage at reset):
  - rollover=1 every cycle, cnt=0, pwm_h=0.
  - After loading P=4, D=1: rollover at cnt=3 only.
- DEADTIME=0, P=4, D=1:
  - pwm_raw=1,0,0,0 repeating.
  - pwm_h is pwm_raw delayed 1 cycle; pwm_l is its complement.
- DEADTIME=2, P=10, D=5, steady state:
  - pwm_h high 3 cycles, dt_active 2, pwm_l 3, dt_active 2 (period 10).
  - pwm_h & pwm_l never both 1.
- DEADTIME=2, P=10, D=1:
  - pwm_h never asserts.
  - dt_active pulses 2 cycles once per period, then pwm_l resumes.
- 100% and 0%:
  - P=6, D=6: pwm_raw constant 1, pwm_h stays high after the initial dead time.
  - D=0: pwm_l stays high.
- en deasserted at cnt=3 (P=10, D=5), then reasserted:
  - Next edge: cnt=0, pwm_h=pwm_l=0, rollover=1.
  - On re-enable: 2 cycles of dead time, then pwm_h.
  - Async rst pulse mid-period gives the same outputs immediately.
